// File: rtl/fifo_tx_bridge_pkg.sv
// Shared constants for the FIFO-to-serializer bridge.
//   DEFAULT_DATA_WIDTH : default byte width of FIFO read data / TX parallel data
//   ST_*               : FSM state encodings used by fifo_tx_bridge
package fifo_tx_bridge_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam logic [1:0] ST_IDLE      = 2'b00;
   localparam logic [1:0] ST_SEND      = 2'b01;
   localparam logic [1:0] ST_WAIT_DONE = 2'b10;

endpackage

// File: rtl/fifo_tx_bridge_sat_counter.sv
// Saturating up-counter used as the offer timeout timer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count one step this cycle
//   tc       : terminal count -- high when the count already sits at LIMIT,
//              or when this cycle's enabled step lands on LIMIT
// LIMIT must be at least 1.
module sat_counter #(
   parameter int LIMIT = 255,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [WIDTH-1:0] LIM    = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && count != LIM)
         count <= count + 1'b1;
   end

   // Look-ahead form so the caller can act in the same cycle the limit is hit.
   assign tc = (count == LIM) || (en && count == LIM_M1);

endmodule

// File: rtl/fifo_tx_bridge.sv
// Pops bytes from a first-word-fall-through FIFO and offers them to a serializer.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   EN            : allows new pops; an in-flight byte always completes
//   FIFO_EMPTY    : FIFO empty flag
//   FIFO_RD_DATA  : FIFO head data, valid while FIFO_EMPTY=0
//   FIFO_R_INC    : one-cycle pop strobe (the head is captured on the same edge)
//   TX_BUSY       : serializer busy; its rise means the offered byte was taken
//   TX_P_DATA     : registered byte offered to the serializer
//   TX_DATA_VALID : byte-offered flag
//   FRAME_CNT     : bytes accepted by the serializer, wraps
//   TIMEOUT_ERR   : sticky, set when an offer goes unanswered TIMEOUT_CYCLES cycles
module fifo_tx_bridge
   import fifo_tx_bridge_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  FIFO_EMPTY,
   input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
   output logic                  FIFO_R_INC,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_DATA_VALID,
   output logic [CNT_WIDTH-1:0]  FRAME_CNT,
   output logic                  TIMEOUT_ERR
);

   logic [1:0] state;
   logic       pop;
   logic       to_en;
   logic       to_tc;

   // Pop is decided combinationally so the FIFO advances on the same edge
   // that captures its head into TX_P_DATA.
   assign pop   = (state == ST_IDLE) && EN && !FIFO_EMPTY && !TX_BUSY;
   // State already reads IDLE during reset; gate so the strobe is quiet then.
   assign FIFO_R_INC = pop && !RST;

   assign to_en = (state == ST_SEND) && !TX_BUSY;

   sat_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk (CLK),
      .rst (RST),
      .clr (pop),
      .en  (to_en),
      .tc  (to_tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= ST_IDLE;
         TX_P_DATA     <= '0;
         TX_DATA_VALID <= 1'b0;
         FRAME_CNT     <= '0;
         TIMEOUT_ERR   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  TX_P_DATA     <= FIFO_RD_DATA;
                  TX_DATA_VALID <= 1'b1;
                  state         <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (TX_BUSY) begin
                  TX_DATA_VALID <= 1'b0;
                  FRAME_CNT     <= FRAME_CNT + 1'b1;
                  state         <= ST_WAIT_DONE;
               end else if (to_tc) begin
                  // Offer unanswered: drop the byte and flag it.
                  TX_DATA_VALID <= 1'b0;
                  TIMEOUT_ERR   <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            ST_WAIT_DONE: begin
               if (!TX_BUSY)
                  state <= ST_IDLE;
            end
            default: begin
               TX_DATA_VALID <= 1'b0;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_tx_bridge.sv
// Directed bench for fifo_tx_bridge with a FIFO stub, a serializer stub and
// a transaction-level reference model compared every cycle.
module tb_fifo_tx_bridge;

   localparam int DW = 8;
   localparam int TO = 255;
   localparam int CW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          EN;
   logic          FIFO_EMPTY;
   logic [DW-1:0] FIFO_RD_DATA;
   logic          FIFO_R_INC;
   logic          TX_BUSY;
   logic [DW-1:0] TX_P_DATA;
   logic          TX_DATA_VALID;
   logic [CW-1:0] FRAME_CNT;
   logic          TIMEOUT_ERR;

   fifo_tx_bridge #(
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO),
      .CNT_WIDTH      (CW)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .EN            (EN),
      .FIFO_EMPTY    (FIFO_EMPTY),
      .FIFO_RD_DATA  (FIFO_RD_DATA),
      .FIFO_R_INC    (FIFO_R_INC),
      .TX_BUSY       (TX_BUSY),
      .TX_P_DATA     (TX_P_DATA),
      .TX_DATA_VALID (TX_DATA_VALID),
      .FRAME_CNT     (FRAME_CNT),
      .TIMEOUT_ERR   (TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- FIFO stub ----------------
   logic [7:0] fifo_q[$];
   task automatic fifo_sync();
      FIFO_EMPTY   = (fifo_q.size() == 0);
      FIFO_RD_DATA = FIFO_EMPTY ? '0 : fifo_q[0];
   endtask
   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      fifo_sync();
   endtask

   // ---------------- serializer stub ----------------
   bit ser_auto  = 1'b1;
   int ser_delay = 1;
   int ser_len   = 10;
   int ser_wait  = 0;
   int ser_left  = 0;
   bit pop_seen  = 1'b0;
   bit valid_seen = 1'b0;

   always @(posedge CLK) begin
      #1;
      if (pop_seen && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         fifo_sync();
      end
      if (TX_BUSY) begin
         ser_left--;
         if (ser_left <= 0) TX_BUSY = 1'b0;
      end else if (ser_auto && valid_seen) begin
         ser_wait++;
         if (ser_wait >= ser_delay) begin
            TX_BUSY  = 1'b1;
            ser_left = ser_len;
            ser_wait = 0;
         end
      end else begin
         ser_wait = 0;
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   // Model view: a byte is either being offered, or has been taken and the
   // serializer is still busy with it, or the bridge is free to pop.
   bit         m_offer, m_wait, m_err;
   logic [7:0] m_data;
   int         m_age, m_cnt;
   int         pops = 0;
   int         valid_run = 0;
   int         max_run = 0;
   logic [7:0] acc[$];

   always @(negedge CLK) begin
      bit exp_pop;
      if (RST) begin
         m_offer = 0; m_wait = 0; m_err = 0; m_data = '0; m_age = 0; m_cnt = 0;
         chk("rst_r_inc", FIFO_R_INC, 0);
         chk("rst_valid", TX_DATA_VALID, 0);
         chk("rst_p_data", TX_P_DATA, 0);
         chk("rst_frame_cnt", FRAME_CNT, 0);
         chk("rst_timeout_err", TIMEOUT_ERR, 0);
         valid_run = 0;
      end else begin
         exp_pop = !m_offer && !m_wait && EN && !FIFO_EMPTY && !TX_BUSY;
         chk("r_inc", FIFO_R_INC, exp_pop);
         chk("valid", TX_DATA_VALID, m_offer);
         chk("p_data", TX_P_DATA, m_data);
         chk("frame_cnt", FRAME_CNT, m_cnt);
         chk("timeout_err", TIMEOUT_ERR, m_err);
         if (FIFO_R_INC) pops++;
         if (TX_DATA_VALID && TX_BUSY) acc.push_back(TX_P_DATA);
         valid_run = TX_DATA_VALID ? valid_run + 1 : 0;
         if (valid_run > max_run) max_run = valid_run;
         // advance to the state after the coming edge
         if (exp_pop) begin
            m_data = FIFO_RD_DATA; m_offer = 1; m_age = 0;
         end else if (m_offer) begin
            if (TX_BUSY) begin
               m_offer = 0; m_wait = 1; m_cnt = (m_cnt + 1) % (1 << CW);
            end else begin
               m_age++;
               if (m_age >= TO) begin m_offer = 0; m_err = 1; end
            end
         end else if (m_wait && !TX_BUSY) begin
            m_wait = 0;
         end
      end
      pop_seen   = FIFO_R_INC;
      valid_seen = TX_DATA_VALID;
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic wait_acc(input int n, input int bound);
      int k = 0;
      while (acc.size() < n && k < bound) begin step(); k++; end
      chk("acc_count_wait", acc.size(), n);
   endtask

   initial begin
      int base, k;
      RST = 1'b1; EN = 1'b0; TX_BUSY = 1'b0;
      fifo_sync();
      step(3);
      chk("reset_p_data", TX_P_DATA, 0);
      chk("reset_frame_cnt", FRAME_CNT, 0);
      RST = 1'b0;
      step(2);

      // single byte: busy rises two cycles into the offer
      ser_delay = 2; ser_len = 3;
      EN = 1'b1;
      push(8'hA5);
      wait_acc(1, 20);
      step(6);
      chk("single_cnt", FRAME_CNT, 1);
      chk("single_byte", acc[0], 8'hA5);
      chk("single_p_data_hold", TX_P_DATA, 8'hA5);

      // burst of 8 bytes, 10 busy cycles each
      ser_delay = 1; ser_len = 10;
      base = pops;
      for (int i = 0; i < 8; i++) push(8'(i));
      wait_acc(9, 300);
      step(12);
      chk("burst_cnt", FRAME_CNT, 9);
      chk("burst_pops", pops - base, 8);
      for (int i = 0; i < 8; i++) chk("burst_order", acc[1 + i], i);

      // timeout on 0x3C, then 0x11 goes through
      ser_auto = 1'b0;
      max_run = 0;
      push(8'h3C);
      push(8'h11);
      k = 0;
      while (!TIMEOUT_ERR && k < 400) begin step(); k++; end
      chk("timeout_set", TIMEOUT_ERR, 1);
      chk("timeout_cnt_unchanged", FRAME_CNT, 9);
      chk("timeout_offer_len", max_run, 255);
      ser_auto = 1'b1;
      wait_acc(10, 30);
      step(12);
      chk("after_timeout_byte", acc[9], 8'h11);
      chk("after_timeout_cnt", FRAME_CNT, 10);
      chk("timeout_sticky", TIMEOUT_ERR, 1);

      // EN drop while serializer busy with the first of three bytes
      base = pops;
      push(8'h21); push(8'h22); push(8'h23);
      k = 0;
      while (!TX_BUSY && k < 20) begin step(); k++; end
      chk("en_drop_busy_seen", TX_BUSY, 1);
      EN = 1'b0;
      step(30);
      chk("en_drop_pops", pops - base, 1);
      chk("en_drop_acc", acc.size(), 11);
      chk("en_drop_queued", fifo_q.size(), 2);
      EN = 1'b1;
      wait_acc(13, 100);
      step(12);
      chk("en_drop_b0", acc[10], 8'h21);
      chk("en_drop_b1", acc[11], 8'h22);
      chk("en_drop_b2", acc[12], 8'h23);
      chk("en_drop_cnt", FRAME_CNT, 13);

      // asynchronous reset mid-offer
      ser_auto = 1'b0;
      push(8'h5A);
      k = 0;
      while (!TX_DATA_VALID && k < 10) begin step(); k++; end
      step(2);
      chk("pre_rst_p_data", TX_P_DATA, 8'h5A);
      RST = 1'b1;
      #1;
      chk("async_rst_p_data", TX_P_DATA, 0);
      chk("async_rst_valid", TX_DATA_VALID, 0);
      chk("async_rst_r_inc", FIFO_R_INC, 0);
      chk("async_rst_cnt", FRAME_CNT, 0);
      chk("async_rst_err", TIMEOUT_ERR, 0);
      step(2);
      acc.delete();
      ser_auto = 1'b1;
      push(8'h66);
      RST = 1'b0;
      wait_acc(1, 20);
      step(12);
      chk("post_rst_byte", acc[0], 8'h66);
      chk("post_rst_cnt", FRAME_CNT, 1);

      // counter wrap
      ser_len = 1;
      for (int i = 0; i < 254; i++) push(8'(i));
      wait_acc(255, 2000);
      step(4);
      chk("wrap_full", FRAME_CNT, 8'hFF);
      push(8'hEE);
      wait_acc(256, 20);
      step(4);
      chk("wrap_zero", FRAME_CNT, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
